// File: rtl/toeplitz_seed_ctrl_pkg.sv
// Shared types and size helpers for the Toeplitz seed loader.
package toeplitz_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_COL, LOAD_ROW, COMMIT_WAIT} seed_state_t;

  function automatic int xsz(input int n, input int bs);
    return n / bs;
  endfunction

  function automatic int ysz(input int l, input int bs);
    return l / bs;
  endfunction

endpackage

// File: rtl/toeplitz_seed_ctrl_if.sv
// Seed stream, datapath handshake and committed-seed outputs of the seed loader.
interface toeplitz_seed_ctrl_if #(
  parameter int BS = 64,
  parameter int N  = 256,
  parameter int L  = 128
);
  logic          load_start;
  logic [BS-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          dp_busy;
  logic [N-1:0]  rrow0;
  logic [L-1:0]  col0;
  logic          seed_valid;
  logic          loading;
  logic          commit_pulse;

  modport master (
    output load_start, wr_data, wr_valid, dp_busy,
    input  wr_ready, rrow0, col0, seed_valid, loading, commit_pulse
  );

  modport slave (
    input  load_start, wr_data, wr_valid, dp_busy,
    output wr_ready, rrow0, col0, seed_valid, loading, commit_pulse
  );
endinterface

// File: rtl/toeplitz_seed_ctrl_assemble.sv
// Packs shadow words into col0 and the reversed, one-bit-shifted first row.
// Purely combinational; word 0 always lands in the MSBs.
module seed_assemble
  import toeplitz_pkg::*;
#(
  parameter int BS = 64,
  parameter int N  = 256,
  parameter int L  = 128,
  localparam int XSZ = xsz(N, BS),
  localparam int YSZ = ysz(L, BS)
) (
  input  logic [BS-1:0] row_words [XSZ],
  input  logic [BS-1:0] col_words [YSZ],
  output logic [N-1:0]  next_rrow0,
  output logic [L-1:0]  next_col0
);

  logic [N-1:0] row_packed;
  logic [N-1:0] row_shift;

  always_comb begin
    row_packed = '0;
    next_col0  = '0;
    next_rrow0 = '0;
    for (int k = 0; k < XSZ; k++) row_packed[N-1-k*BS -: BS] = row_words[k];
    for (int k = 0; k < YSZ; k++) next_col0[L-1-k*BS -: BS] = col_words[k];
    // Row MSB is shared with the column, so it falls off the top here.
    row_shift = row_packed << 1;
    for (int i = 0; i < N; i++) next_rrow0[i] = row_shift[N-1-i];
  end

endmodule

// File: rtl/toeplitz_seed_ctrl.sv
// Double-buffered Toeplitz seed loader: column words, then row words, into shadow regs;
// commit to the outputs atomically once the datapath is idle.
module toeplitz_seed_ctrl
  import toeplitz_pkg::*;
#(
  parameter int BS = 64,
  parameter int N  = 256,
  parameter int L  = 128
) (
  input logic                clk,
  input logic                rst,
  toeplitz_seed_ctrl_if.slave sif
);

  localparam int XSZ = xsz(N, BS);
  localparam int YSZ = ysz(L, BS);
  localparam int CW  = $clog2(XSZ + YSZ + 1);

  if ((N % BS) != 0 || (L % BS) != 0) begin : g_size_err
    $error("toeplitz_seed_ctrl: N and L must be multiples of BS");
  end

  seed_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BS-1:0] c_q [YSZ];
  logic [BS-1:0] c_d [YSZ];
  logic [BS-1:0] r_q [XSZ];
  logic [BS-1:0] r_d [XSZ];
  logic [N-1:0]  rrow0_q, rrow0_d;
  logic [L-1:0]  col0_q, col0_d;
  logic          seed_valid_q, seed_valid_d;
  logic          commit_pulse_q, commit_pulse_d;

  logic [N-1:0]  next_rrow0;
  logic [L-1:0]  next_col0;
  logic          wr_ready;
  logic          beat;

  seed_assemble #(.BS(BS), .N(N), .L(L)) u_assemble (
    .row_words  (r_q),
    .col_words  (c_q),
    .next_rrow0 (next_rrow0),
    .next_col0  (next_col0)
  );

  assign wr_ready = (state_q == LOAD_COL) || (state_q == LOAD_ROW);
  assign beat     = sif.wr_valid && wr_ready;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    c_d            = c_q;
    r_d            = r_q;
    rrow0_d        = rrow0_q;
    col0_d         = col0_q;
    seed_valid_d   = seed_valid_q;
    commit_pulse_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sif.load_start) begin
          state_d = LOAD_COL;
          cnt_d   = '0;
        end
      end
      LOAD_COL: begin
        if (sif.load_start) begin
          cnt_d = '0;
        end else if (beat) begin
          for (int k = 0; k < YSZ; k++)
            if (cnt_q == CW'(k)) c_d[k] = sif.wr_data;
          if (cnt_q == CW'(YSZ - 1)) begin
            state_d = LOAD_ROW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_ROW: begin
        if (sif.load_start) begin
          state_d = LOAD_COL;
          cnt_d   = '0;
        end else if (beat) begin
          for (int k = 0; k < XSZ; k++)
            if (cnt_q == CW'(k)) r_d[k] = sif.wr_data;
          if (cnt_q == CW'(XSZ - 1)) begin
            state_d = COMMIT_WAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMMIT_WAIT: begin
        if (!sif.dp_busy) begin
          rrow0_d        = next_rrow0;
          col0_d         = next_col0;
          seed_valid_d   = 1'b1;
          commit_pulse_d = 1'b1;
          state_d        = IDLE;
        end
        // A restart still lets a same-cycle commit through first.
        if (sif.load_start) begin
          state_d = LOAD_COL;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      for (int k = 0; k < YSZ; k++) c_q[k] <= '0;
      for (int k = 0; k < XSZ; k++) r_q[k] <= '0;
      rrow0_q        <= '0;
      col0_q         <= '0;
      seed_valid_q   <= 1'b0;
      commit_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      c_q            <= c_d;
      r_q            <= r_d;
      rrow0_q        <= rrow0_d;
      col0_q         <= col0_d;
      seed_valid_q   <= seed_valid_d;
      commit_pulse_q <= commit_pulse_d;
    end
  end

  assign sif.wr_ready     = wr_ready;
  assign sif.rrow0        = rrow0_q;
  assign sif.col0         = col0_q;
  assign sif.seed_valid   = seed_valid_q;
  assign sif.loading      = (state_q != IDLE);
  assign sif.commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_toeplitz_seed_ctrl.sv
// Bench for toeplitz_seed_ctrl at BS=4, N=8, L=8 with a queue-based seed model.
module tb_toeplitz_seed_ctrl;

  localparam int BS = 4;
  localparam int N  = 8;
  localparam int L  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  toeplitz_seed_ctrl_if #(.BS(BS), .N(N), .L(L)) sif ();

  toeplitz_seed_ctrl #(.BS(BS), .N(N), .L(L)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int acc_beats = 0;
  int pulses   = 0;
  int last_pulse_cyc = -1;
  int last_acc_cyc   = 0;
  bit chk_en = 1'b0;

  // Model: a load is the list of words accepted since load_start; four words make a seed.
  logic [3:0] m_words[$];
  bit         m_active = 1'b0;
  bit         m_valid  = 1'b0;
  bit         m_pulse  = 1'b0;
  logic [7:0] m_col    = 8'h00;
  logic [7:0] m_rrow   = 8'h00;

  function automatic logic [7:0] rev_shift(input logic [7:0] row);
    logic [7:0] sh;
    logic [7:0] r;
    sh = 8'((int'(row) * 2) % 256);
    for (int i = 0; i < 8; i++) r[i] = sh[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit acc;
    cyc_cnt++;
    if (rst) begin
      m_words.delete();
      m_active = 1'b0;
      m_valid  = 1'b0;
      m_pulse  = 1'b0;
      m_col    = 8'h00;
      m_rrow   = 8'h00;
    end else begin
      acc = m_active && (m_words.size() < 4) && sif.wr_valid;
      if (sif.wr_valid && sif.wr_ready) acc_beats++;
      m_pulse = 1'b0;
      if (m_active && m_words.size() == 4 && !sif.dp_busy) begin
        m_col    = {m_words[0], m_words[1]};
        m_rrow   = rev_shift({m_words[2], m_words[3]});
        m_valid  = 1'b1;
        m_pulse  = 1'b1;
        m_active = 1'b0;
      end
      if (sif.load_start) begin
        m_active = 1'b1;
        m_words.delete();
      end else if (acc) begin
        m_words.push_back(sif.wr_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_ready",     sif.wr_ready,     m_active && (m_words.size() < 4));
      check("loading",      sif.loading,      m_active);
      check("seed_valid",   sif.seed_valid,   m_valid);
      check("col0",         sif.col0,         m_col);
      check("rrow0",        sif.rrow0,        m_rrow);
      check("commit_pulse", sif.commit_pulse, m_pulse);
      if (sif.commit_pulse) begin
        pulses++;
        last_pulse_cyc = cyc_cnt;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_load();
    sif.load_start = 1'b1;
    cyc();
    sif.load_start = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input int gap_pct);
    bit done = 1'b0;
    int t = 0;
    while (!done && t < 64) begin
      sif.wr_valid = ($urandom_range(99) >= gap_pct);
      sif.wr_data  = sif.wr_valid ? w : 4'($urandom);
      done = sif.wr_valid && sif.wr_ready;
      cyc();
      t++;
    end
    sif.wr_valid = 1'b0;
    last_acc_cyc = cyc_cnt;
    check("send_word_accepted", done, 1'b1);
  endtask

  task automatic send4(input logic [15:0] ws, input int gap_pct);
    for (int i = 3; i >= 0; i--) send_word(ws[i*4 +: 4], gap_pct);
  endtask

  initial begin : stim
    int base_pulses;
    int base_beats;
    sif.load_start = 1'b0;
    sif.wr_valid   = 1'b0;
    sif.wr_data    = '0;
    sif.dp_busy    = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (5) cyc();
    check("t1_col0", sif.col0, 8'h00);
    check("t1_rrow0", sif.rrow0, 8'h00);
    check("t1_seed_valid", sif.seed_valid, 1'b0);
    check("t1_wr_ready", sif.wr_ready, 1'b0);

    // Basic load, datapath idle
    start_load();
    send4(16'hA581, 0);
    repeat (4) cyc();
    check("t2_col0", sif.col0, 8'hA5);
    check("t2_rrow0", sif.rrow0, 8'h40);
    check("t2_seed_valid", sif.seed_valid, 1'b1);
    check("t2_pulses", pulses, 1);
    check("t2_commit_latency", last_pulse_cyc, last_acc_cyc + 1);

    // Reload held off by a busy datapath
    sif.dp_busy = 1'b1;
    start_load();
    send4(16'h3CFF, 0);
    repeat (10) cyc();
    check("t3_hold_col0", sif.col0, 8'hA5);
    check("t3_hold_rrow0", sif.rrow0, 8'h40);
    check("t3_hold_pulses", pulses, 1);
    sif.dp_busy = 1'b0;
    repeat (3) cyc();
    check("t3_col0", sif.col0, 8'h3C);
    check("t3_rrow0", sif.rrow0, 8'h7F);
    check("t3_pulses", pulses, 2);

    // Gappy valid
    base_beats = acc_beats;
    start_load();
    send4(16'hA581, 50);
    repeat (3) cyc();
    check("t4_beats", acc_beats - base_beats, 4);
    check("t4_col0", sif.col0, 8'hA5);
    check("t4_rrow0", sif.rrow0, 8'h40);

    // Abort after three beats; the restart cycle also carries a discarded beat
    start_load();
    send_word(4'hE, 0);
    send_word(4'hE, 0);
    send_word(4'hE, 0);
    sif.load_start = 1'b1;
    sif.wr_valid   = 1'b1;
    sif.wr_data    = 4'h7;
    cyc();
    sif.load_start = 1'b0;
    sif.wr_valid   = 1'b0;
    send4(16'h1248, 0);
    repeat (3) cyc();
    check("t5_col0", sif.col0, 8'h12);
    check("t5_rrow0", sif.rrow0, 8'h09);

    // load_start coinciding with the commit cycle
    sif.dp_busy = 1'b1;
    start_load();
    send4(16'h6699, 0);
    repeat (2) cyc();
    base_pulses = pulses;
    sif.dp_busy    = 1'b0;
    sif.load_start = 1'b1;
    cyc();
    sif.load_start = 1'b0;
    check("tc_col0", sif.col0, 8'h66);
    check("tc_rrow0", sif.rrow0, 8'h4C);
    check("tc_loading", sif.loading, 1'b1);
    cyc();
    check("tc_pulses", pulses, base_pulses + 1);
    send4(16'h1111, 0);
    repeat (3) cyc();
    check("tc2_rrow0", sif.rrow0, 8'h44);

    // Reset while in the row phase
    start_load();
    send_word(4'h1, 0);
    send_word(4'h2, 0);
    send_word(4'h3, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_seed_valid", sif.seed_valid, 1'b0);
    check("t6_col0", sif.col0, 8'h00);
    check("t6_rrow0", sif.rrow0, 8'h00);
    check("t6_wr_ready", sif.wr_ready, 1'b0);
    check("t6_loading", sif.loading, 1'b0);

    // Free-running random traffic against the model
    for (int i = 0; i < 600; i++) begin
      sif.load_start = ($urandom_range(19) == 0);
      sif.wr_valid   = ($urandom_range(9) < 6);
      sif.wr_data    = 4'($urandom);
      sif.dp_busy    = ($urandom_range(9) < 4);
      cyc();
    end
    sif.load_start = 1'b0;
    sif.wr_valid   = 1'b0;
    sif.dp_busy    = 1'b0;
    repeat (4) cyc();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
